seq_sub128: RTL and testbench

SEQ_SUB128 -- requirements
Module: seq_sub128

---
 rtl/seq_sub128_pkg.sv | 14 +
 rtl/seq_sub128_cra32bits.sv | 23 ++
 rtl/seq_sub128.sv | 109 ++++++++++
 tb/tb_seq_sub128.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/seq_sub128_pkg.sv
// Shared definitions for the sequential slice subtractor:
// FSM state encoding and default operand/slice widths.
package seq_sub_pkg;

    localparam int N_DEF = 128;
    localparam int W_DEF = 32;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

// File: rtl/seq_sub128_cra32bits.sv
// 32-bit carry-ripple adder used as the per-cycle slice datapath.
// s = a + b + cin, cout is the carry out of bit 31.
module cra32bits (
    input  logic [31:0] a_i,
    input  logic [31:0] b_i,
    input  logic        cin_i,
    output logic [31:0] s_o,
    output logic        cout_o
);

    // Bit-serial ripple of the carry through 32 full adders
    always_comb begin
        logic c;
        c = cin_i;
        s_o = '0;
        for (int i = 0; i < 32; i++) begin
            s_o[i] = a_i[i] ^ b_i[i] ^ c;
            c = (a_i[i] & b_i[i]) | (c & (a_i[i] ^ b_i[i]));
        end
        cout_o = c;
    end

endmodule

// File: rtl/seq_sub128.sv
// Multi-cycle N-bit subtractor: d = a - b - bin, one W-bit slice
// per cycle LSB first, borrow carried between slices as ~carry.
module seq_sub128
    import seq_sub_pkg::*;
#(
    parameter int N = N_DEF,
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] a,
    input  logic [N-1:0] b,
    input  logic         bin,
    output logic         busy,
    output logic         done,
    output logic [N-1:0] d,
    output logic         bout
);

    localparam int S  = N / W;
    localparam int CW = (S > 1) ? $clog2(S) : 1;
    localparam logic [CW-1:0] LAST = CW'(S - 1);

    state_t          state_q;
    logic [N-1:0]    a_q;
    logic [N-1:0]    b_q;
    logic [N-1:0]    d_q;
    logic            c_q;
    logic            bout_q;
    logic            busy_q;
    logic            done_q;
    logic [CW-1:0]   cnt_q;

    logic [W-1:0]    sl_a;
    logic [W-1:0]    sl_b;
    logic [W-1:0]    sl_s;
    logic            sl_c;

    // Select the current slice of the captured operands
    always_comb begin
        sl_a = a_q[cnt_q*W +: W];
        sl_b = b_q[cnt_q*W +: W];
    end

    // Subtraction as a + ~b + carry; carry = ~borrow
    cra32bits u_cra (
        .a_i    (sl_a),
        .b_i    (~sl_b),
        .cin_i  (c_q),
        .s_o    (sl_s),
        .cout_o (sl_c)
    );

    // Control FSM with registered busy/done and datapath state
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            a_q     <= '0;
            b_q     <= '0;
            d_q     <= '0;
            c_q     <= 1'b0;
            bout_q  <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            unique case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= a;
                        b_q     <= b;
                        c_q     <= ~bin;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                        state_q <= S_RUN;
                    end
                end
                S_RUN: begin
                    d_q[cnt_q*W +: W] <= sl_s;
                    c_q <= sl_c;
                    if (cnt_q == LAST) begin
                        bout_q  <= ~sl_c;
                        done_q  <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                S_DONE: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
                default: begin
                    done_q  <= 1'b0;
                    busy_q  <= 1'b0;
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule

// File: tb/tb_seq_sub128.sv
// Directed-vector bench for seq_sub128: latency, borrow ripple,
// start masking, mid-run reset and back-to-back operation.
module tb_seq_sub128;

    logic         clk = 1'b0;
    logic         rst;
    logic         start;
    logic [127:0] a;
    logic [127:0] b;
    logic         bin;
    logic         busy;
    logic         done;
    logic [127:0] d;
    logic         bout;

    int nvec = 0;
    int nerr = 0;

    localparam logic [127:0] ONES = {128{1'b1}};

    seq_sub128 dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .d     (d),
        .bout  (bout)
    );

    always #5 clk = ~clk;

    task automatic test_reset();
        rst = 1'b1; start = 1'b1;
        a = 128'd9; b = 128'd1; bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        nvec++;
        if ({busy, done, bout} !== 3'b000 || d !== '0) begin
            nerr++;
            $display("FAIL reset: busy=%b done=%b bout=%b d=%h req 0",
                     busy, done, bout, d);
        end
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        nvec++;
        if (busy !== 1'b0) begin
            nerr++;
            $display("FAIL reset_prio: busy=%b req 0", busy);
        end
    endtask

    // Start at edge T; check busy/done timing and result at T+5
    task automatic run_op(input logic [127:0] va,
                          input logic [127:0] vb,
                          input logic         vbin,
                          input logic [127:0] ed,
                          input logic         eb,
                          input string        nm);
        @(negedge clk);
        a = va; b = vb; bin = vbin; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 8; cyc++) begin
            @(negedge clk);
            nvec++;
            if (busy !== (cyc <= 5) || done !== (cyc == 5)) begin
                nerr++;
                $display("FAIL %s_timing c%0d: busy=%b done=%b req %b %b",
                         nm, cyc, busy, done, cyc <= 5, cyc == 5);
            end
            if (cyc == 5 || cyc == 8) begin
                nvec++;
                if (d !== ed || bout !== eb) begin
                    nerr++;
                    $display("FAIL %s c%0d: d=%h bout=%b req d=%h bout=%b",
                             nm, cyc, d, bout, ed, eb);
                end
            end
        end
    endtask

    task automatic test_arith();
        run_op(128'd5, 128'd3, 1'b0, 128'd2, 1'b0, "5m3");
        run_op(128'd0, 128'd1, 1'b0, ONES, 1'b1, "0m1");
        run_op(128'h1 << 64, 128'd1, 1'b0,
               {64'h0, 64'hFFFF_FFFF_FFFF_FFFF}, 1'b0, "slice2");
        run_op(128'h0123456789ABCDEF0123456789ABCDEF,
               128'h0123456789ABCDEF0123456789ABCDEF, 1'b1,
               ONES, 1'b1, "eq_bin");
        run_op(ONES, 128'd0, 1'b1, ONES - 128'd1, 1'b0, "max");
    endtask

    task automatic test_ignore_start();
        @(negedge clk);
        a = 128'd100; b = 128'd58; bin = 1'b1; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 7; cyc++) begin
            @(negedge clk);
            if (cyc == 2) begin
                a = 128'd7; b = 128'd9; bin = 1'b0; start = 1'b1;
            end
            if (cyc == 3) start = 1'b0;
            nvec++;
            if (busy !== (cyc <= 5) || done !== (cyc == 5)) begin
                nerr++;
                $display("FAIL ign_timing c%0d: busy=%b done=%b", cyc,
                         busy, done);
            end
            if (cyc == 5) begin
                nvec++;
                if (d !== 128'd41 || bout !== 1'b0) begin
                    nerr++;
                    $display("FAIL ign_res: d=%h bout=%b req 29 0",
                             d, bout);
                end
            end
        end
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        a = 128'd0; b = 128'd1; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int cyc = 1; cyc <= 9; cyc++) begin
            @(negedge clk);
            if (cyc == 2) rst = 1'b1;
            if (cyc == 3) begin
                rst = 1'b0;
                nvec++;
                if (busy !== 1'b0 || d !== '0 || bout !== 1'b0) begin
                    nerr++;
                    $display("FAIL mid_rst: busy=%b d=%h bout=%b req 0",
                             busy, d, bout);
                end
            end
            if (cyc >= 3) begin
                nvec++;
                if (done !== 1'b0) begin
                    nerr++;
                    $display("FAIL mid_rst_done c%0d: done=%b req 0",
                             cyc, done);
                end
            end
        end
        run_op(128'd1000, 128'd1, 1'b0, 128'd999, 1'b0, "after_rst");
    endtask

    task automatic test_back_to_back();
        int t_done1 = 0;
        int t_done2 = 0;
        @(negedge clk);
        a = 128'd50; b = 128'd20; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc <= 14; cyc++) begin
            @(negedge clk);
            if (cyc == 6) begin
                a = 128'd3; b = 128'd4; bin = 1'b0;
            end
            if (cyc == 7) start = 1'b0;
            if (done === 1'b1) begin
                if (t_done1 == 0) t_done1 = cyc;
                else if (t_done2 == 0) t_done2 = cyc;
            end
            if (cyc == 5) begin
                nvec++;
                if (d !== 128'd30 || bout !== 1'b0) begin
                    nerr++;
                    $display("FAIL b2b_r1: d=%h bout=%b req 1e 0", d, bout);
                end
            end
            if (cyc == 6) begin
                nvec++;
                if (busy !== 1'b0) begin
                    nerr++;
                    $display("FAIL b2b_idle: busy=%b req 0", busy);
                end
            end
            if (cyc == 11) begin
                nvec++;
                if (d !== ONES || bout !== 1'b1) begin
                    nerr++;
                    $display("FAIL b2b_r2: d=%h bout=%b req ones 1",
                             d, bout);
                end
            end
        end
        nvec++;
        if (t_done1 != 5 || t_done2 != 11) begin
            nerr++;
            $display("FAIL b2b_done: at %0d,%0d req 5,11",
                     t_done1, t_done2);
        end
    endtask

    initial begin
        test_reset();
        test_arith();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
